eink_line_buffer: RTL and testbench



---
 rtl/eink_line_buffer_if.sv | 24 ++
 rtl/eink_line_buffer.sv | 141 ++++++++++++++
 tb/tb_eink_line_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/eink_line_buffer_if.sv
// eink_line_buffer_if: pixel input, line control and source-word read bus of the e-ink line buffer.
// master = frame/waveform engine plus timing controller side, slave = the line buffer.
interface eink_line_buffer_if;
  logic        frame_start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_pix;
  logic        line_swap;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        line_valid;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  modport master (
    output frame_start, in_valid, in_pix, line_swap, rd_en,
    input  in_ready, rd_data, line_valid, underrun, underrun_cnt
  );

  modport slave (
    input  frame_start, in_valid, in_pix, line_swap, rd_en,
    output in_ready, rd_data, line_valid, underrun, underrun_cnt
  );
endinterface

// File: rtl/eink_line_buffer.sv
// eink_line_buffer: packs 2-bit pixel codes MSB-first into 16-bit words in ping-pong line banks; rd_data 1 cycle after rd_en.
// Backpressure: in_ready (registered) drops while the fill bank is full until line_swap; EINK_LB_UNDERRUN_REPEAT_EN repeats the last line on underrun.
module eink_line_buffer #(
  parameter int WORDS_PER_LINE = 100,
  parameter int AW             = 7
) (
  input  logic             clk,
  input  logic             rst,
  eink_line_buffer_if.slave bus
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS_PER_LINE - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  logic [15:0] mem_q [2][WORDS_PER_LINE];

  logic          fill_q, fill_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]    pix_cnt_q, pix_cnt_d;
  logic [15:0]   word_q, word_d;
  logic          fill_full_q, fill_full_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          line_valid_q, line_valid_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    underrun_cnt_q, underrun_cnt_d;

  logic          accept;
  logic          word_done;
  logic          last_wr;
  logic          wr_en;
  logic [15:0]   wr_word;
  logic          rd_bank;

  assign rd_bank = ~fill_q;

  always_comb begin
    fill_d         = fill_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    pix_cnt_d      = pix_cnt_q;
    word_d         = word_q;
    fill_full_d    = fill_full_q;
    rd_data_d      = rd_data_q;
    line_valid_d   = line_valid_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;

    accept    = bus.in_valid && in_ready_q;
    word_done = accept && (pix_cnt_q == 3'd7);
    last_wr   = word_done && (wr_addr_q == ADDR_LAST);
    wr_word   = {word_q[13:0], bus.in_pix};
    wr_en     = word_done && !bus.frame_start;

    if (accept) begin
      word_d    = wr_word;
      pix_cnt_d = pix_cnt_q + 3'd1;
    end
    if (word_done) begin
      if (last_wr) fill_full_d = 1'b1;
      else         wr_addr_d   = wr_addr_q + ADDR_ONE;
    end

    // A swap on the same cycle as the final write still counts as a complete line.
    if (bus.line_swap) begin
      rd_addr_d = '0;
      if (fill_full_q || last_wr) begin
        fill_d       = ~fill_q;
        fill_full_d  = 1'b0;
        wr_addr_d    = '0;
        pix_cnt_d    = '0;
        word_d       = '0;
        line_valid_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
`ifndef EINK_LB_UNDERRUN_REPEAT_EN
        line_valid_d = 1'b0;
`endif
      end
    end else if (bus.rd_en) begin
      rd_data_d = line_valid_q ? mem_q[rd_bank][rd_addr_q] : 16'h0000;
      if (rd_addr_q != ADDR_LAST) rd_addr_d = rd_addr_q + ADDR_ONE;
    end

    if (bus.frame_start) begin
      fill_d       = 1'b0;
      wr_addr_d    = '0;
      rd_addr_d    = '0;
      pix_cnt_d    = '0;
      word_d       = '0;
      fill_full_d  = 1'b0;
      rd_data_d    = 16'h0000;
      line_valid_d = 1'b0;
      underrun_d   = 1'b0;
    end

    in_ready_d = !fill_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q         <= 1'b0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      pix_cnt_q      <= '0;
      word_q         <= '0;
      fill_full_q    <= 1'b0;
      in_ready_q     <= 1'b1;
      rd_data_q      <= 16'h0000;
      line_valid_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'h00;
    end else begin
      fill_q         <= fill_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      pix_cnt_q      <= pix_cnt_d;
      word_q         <= word_d;
      fill_full_q    <= fill_full_d;
      in_ready_q     <= in_ready_d;
      rd_data_q      <= rd_data_d;
      line_valid_q   <= line_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // Banks carry no reset; line_valid gates every read of stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[fill_q][wr_addr_q] <= wr_word;
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_eink_line_buffer.sv
// tb_eink_line_buffer: drives pixel lines, swaps and reads; a line model feeds a scoreboard of expected rd_data words.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_eink_line_buffer;

  logic clk;
  logic rst;
  eink_line_buffer_if bus();

  eink_line_buffer #(.WORDS_PER_LINE(100), .AW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errs;

  logic [15:0] m_fill [100];
  logic [15:0] m_read [100];
  logic [15:0] m_word;
  int          m_wa, m_pc, m_ra, m_cnt;
  bit          m_full, m_lv, m_und;
  logic [15:0] exp_q [$];
  bit          rd_issued;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit keep_cnt);
    m_word = '0; m_wa = 0; m_pc = 0; m_ra = 0;
    m_full = 0; m_lv = 0; m_und = 0;
    if (!keep_cnt) m_cnt = 0;
  endtask

  task automatic model_update();
    if (bus.frame_start) begin
      model_reset(1);
      return;
    end
    if (bus.in_valid && !m_full) begin
      m_word = {m_word[13:0], bus.in_pix};
      m_pc++;
      if (m_pc == 8) begin
        m_fill[m_wa] = m_word;
        m_pc = 0;
        if (m_wa == 99) m_full = 1;
        else            m_wa++;
      end
    end
    if (bus.line_swap) begin
      m_ra = 0;
      if (m_full) begin
        for (int i = 0; i < 100; i++) m_read[i] = m_fill[i];
        m_lv = 1; m_full = 0; m_wa = 0; m_pc = 0;
      end else begin
        m_und = 1;
        if (m_cnt < 255) m_cnt++;
`ifndef EINK_LB_UNDERRUN_REPEAT_EN
        m_lv = 0;
`endif
      end
    end else if (bus.rd_en) begin
      exp_q.push_back(m_lv ? m_read[m_ra] : 16'h0000);
      rd_issued = 1;
      if (m_ra < 99) m_ra++;
    end
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    if (rd_issued) begin
      rd_issued = 0;
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
    bus.in_valid = 0; bus.line_swap = 0; bus.rd_en = 0; bus.frame_start = 0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_in_ready"},     32'(bus.in_ready),     32'(!m_full));
    chk({tag, "_line_valid"},   32'(bus.line_valid),   32'(m_lv));
    chk({tag, "_underrun"},     32'(bus.underrun),     32'(m_und));
    chk({tag, "_underrun_cnt"}, 32'(bus.underrun_cnt), 32'(m_cnt));
  endtask

  function automatic logic [1:0] pix_of(input int kind, input int i);
    logic [1:0] p;
    case (kind)
      0:       p = i[0] ? 2'b10 : 2'b01;
      1:       p = i[1:0];
      default: p = 2'($urandom_range(0, 3));
    endcase
    return p;
  endfunction

  task automatic feed(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1;
      bus.in_pix   = pix_of(kind, i);
      step();
    end
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rd_en = 1;
      step();
    end
  endtask

  task automatic swap();
    bus.line_swap = 1;
    step();
  endtask

  initial begin
    n_checks = 0; n_errs = 0; rd_issued = 0;
    rst = 1;
    bus.frame_start = 0; bus.in_valid = 0; bus.in_pix = 0; bus.line_swap = 0; bus.rd_en = 0;
    model_reset(0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_line_valid", 32'(bus.line_valid), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_underrun_cnt", 32'(bus.underrun_cnt), 32'd0);
    rst = 0;
    @(negedge clk);

    // Full line of 01,10 pixels; in_ready must stay low until the swap.
    feed(800, 0);
    check_flags("full0");
    bus.in_valid = 1; bus.in_pix = 2'b11;
    step();
    for (int i = 0; i < 3; i++) check_flags("full_hold");
    swap();
    check_flags("swap0");
    reads(1);
    chk("word0_6666", 32'(bus.rd_data), 32'h6666);
    reads(99);

    // MSB-first packing order.
    feed(800, 1);
    swap();
    check_flags("swap1");
    reads(1);
    chk("word0_1b1b", 32'(bus.rd_data), 32'h1B1B);

    // Random line, read past the end to exercise address saturation.
    feed(800, 2);
    swap();
    reads(105);
    chk("sat_last_word", 32'(bus.rd_data), 32'(m_read[99]));

    // Underrun after 50 words, then complete and swap again.
    feed(400, 2);
    swap();
    check_flags("underrun");
    reads(3);
    feed(400, 2);
    check_flags("refill_full");
    swap();
    check_flags("after_refill");
    reads(100);

    // Swap on the same cycle as the 800th pixel.
    feed(799, 2);
    bus.in_valid = 1; bus.in_pix = 2'b11; bus.line_swap = 1;
    step();
    check_flags("swap_same_cycle");
    reads(100);

    // frame_start mid-fill.
    feed(333, 2);
    bus.frame_start = 1; bus.in_valid = 1; bus.in_pix = 2'b01;
    step();
    check_flags("frame_start");
    chk("fs_rd_data", 32'(bus.rd_data), 32'h0);
    reads(2);
    feed(800, 2);
    swap();
    check_flags("fs_clean_line");
    reads(100);

    // Asynchronous reset in the middle of a read burst.
    reads(3);
    bus.rd_en = 1;
    #2 rst = 1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("arst_line_valid", 32'(bus.line_valid), 32'd0);
    chk("arst_underrun", 32'(bus.underrun), 32'd0);
    chk("arst_underrun_cnt", 32'(bus.underrun_cnt), 32'd0);
    bus.rd_en = 0;
    exp_q.delete();
    model_reset(0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_flags("post_rst");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
